// File: rtl/metro_pkg.sv
// rtl/metro_pkg.sv - shared types and constants for the metro schedule controller
package metro_pkg;

  localparam int DIG_W = 5;
  localparam logic [DIG_W-1:0] DIG_BLANK = 5'd16;
  localparam logic [DIG_W-1:0] DIG_DASH  = 5'd17;

  localparam logic [4:0] ARRIVE_LAST = 5'd19;
  localparam logic [3:0] PRESC_LAST  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_ARRIVE,
    ST_DWELL,
    ST_HOLD
  } state_t;

  function automatic logic [7:0] to_bcd2(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [DIG_W-1:0] dig(input logic [3:0] n);
    return {1'b0, n};
  endfunction

endpackage

// File: rtl/bcd_down_cnt.sv
// rtl/bcd_down_cnt.sv - 2-digit BCD down-counter with load, enable, wrap value and borrow-out
module bcd_down_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  input  logic [7:0] wrap_val,
  output logic [7:0] value,
  output logic [7:0] value_nxt,
  output logic       borrow
);

  // value_nxt is exported so the parent can register outputs with no extra latency
  always_comb begin
    value_nxt = value;
    if (load) begin
      value_nxt = load_val;
    end else if (en) begin
      if (value == 8'h00)
        value_nxt = wrap_val;
      else if (value[3:0] == 4'd0)
        value_nxt = {value[7:4] - 4'd1, 4'd9};
      else
        value_nxt = {value[7:4], value[3:0] - 4'd1};
    end
  end

  assign borrow = en && (value == 8'h00);

  always_ff @(posedge clk) begin
    if (reset) value <= 8'h00;
    else       value <= value_nxt;
  end

endmodule

// File: rtl/metro_sched_ctrl.sv
// rtl/metro_sched_ctrl.sv - metro arrival countdown / dwell scheduler driving a 4-digit display
module metro_sched_ctrl
  import metro_pkg::*;
#(
  parameter int unsigned INTERVAL_MM = 2,
  parameter int unsigned INTERVAL_SS = 30,
  parameter int unsigned DWELL_S     = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_10hz,
  input  logic             start,
  input  logic             hold,
  output logic [DIG_W-1:0] ones,
  output logic [DIG_W-1:0] tens,
  output logic [DIG_W-1:0] hundreds,
  output logic [DIG_W-1:0] thousands,
  output logic             door_open,
  output logic             arriving,
  output logic [7:0]       train_cnt
);

  state_t state, state_nxt, saved_state;
  logic [3:0] presc, presc_nxt;
  logic [4:0] arr_cnt, arr_nxt;
  logic [7:0] mm, mm_nxt, ss, ss_nxt, dw, dw_nxt;
  logic ss_borrow, mm_borrow_unused, dw_borrow;
  logic sec_evt, count_evt, dwell_evt, dwell_done, arrive_done, cd_zero, reload;
  logic [DIG_W-1:0] ones_nxt, tens_nxt, hundreds_nxt, thousands_nxt;

  assign sec_evt     = tick_10hz && (presc == PRESC_LAST);
  assign cd_zero     = (mm == 8'h00) && (ss == 8'h00);
  assign count_evt   = (state == ST_COUNT) && !hold && sec_evt;
  assign dwell_evt   = (state == ST_DWELL) && !hold && sec_evt;
  // Dwell ends on the event that would take it to 00, so it lasts DWELL_S seconds
  assign dwell_done  = dwell_evt && ((dw == 8'h01) || dw_borrow);
  assign arrive_done = (state == ST_ARRIVE) && !hold && tick_10hz && (arr_cnt == ARRIVE_LAST);
  assign reload      = ((state == ST_IDLE) && start) || dwell_done;

  bcd_down_cnt u_ss (
    .clk(clk), .reset(reset), .load(reload), .load_val(to_bcd2(INTERVAL_SS)),
    .en(count_evt && !cd_zero), .wrap_val(8'h59),
    .value(ss), .value_nxt(ss_nxt), .borrow(ss_borrow)
  );

  bcd_down_cnt u_mm (
    .clk(clk), .reset(reset), .load(reload), .load_val({4'd0, 4'(INTERVAL_MM)}),
    .en(ss_borrow), .wrap_val(8'h00),
    .value(mm), .value_nxt(mm_nxt), .borrow(mm_borrow_unused)
  );

  bcd_down_cnt u_dw (
    .clk(clk), .reset(reset), .load(arrive_done), .load_val(to_bcd2(DWELL_S)),
    .en(dwell_evt), .wrap_val(8'h00),
    .value(dw), .value_nxt(dw_nxt), .borrow(dw_borrow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      saved_state <= ST_IDLE;
      presc       <= 4'd0;
      arr_cnt     <= 5'd0;
      train_cnt   <= 8'd0;
    end else begin
      state   <= state_nxt;
      presc   <= presc_nxt;
      arr_cnt <= arr_nxt;
      if (state_nxt == ST_HOLD && state != ST_HOLD) saved_state <= state;
      if (dwell_done) train_cnt <= train_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_COUNT;
      ST_COUNT:  if (hold) state_nxt = ST_HOLD;
                 else if (count_evt && cd_zero) state_nxt = ST_ARRIVE;
      ST_ARRIVE: if (hold) state_nxt = ST_HOLD;
                 else if (arrive_done) state_nxt = ST_DWELL;
      ST_DWELL:  if (hold) state_nxt = ST_HOLD;
                 else if (dwell_done) state_nxt = ST_COUNT;
      ST_HOLD:   if (!hold) state_nxt = saved_state;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Entering or leaving HOLD keeps the prescaler so the schedule resumes mid-second
  always_comb begin
    presc_nxt = presc;
    arr_nxt   = arr_cnt;
    if (state != ST_HOLD && state_nxt != ST_HOLD) begin
      if (state_nxt != state)
        presc_nxt = 4'd0;
      else if (tick_10hz && state != ST_IDLE)
        presc_nxt = (presc == PRESC_LAST) ? 4'd0 : presc + 4'd1;
      if (state == ST_COUNT && state_nxt == ST_ARRIVE)
        arr_nxt = 5'd0;
      else if (state == ST_ARRIVE && state_nxt == ST_ARRIVE && tick_10hz)
        arr_nxt = arr_cnt + 5'd1;
    end
  end

  always_comb begin
    thousands_nxt = thousands;
    hundreds_nxt  = hundreds;
    tens_nxt      = tens;
    ones_nxt      = ones;
    case (state_nxt)
      ST_IDLE: begin
        thousands_nxt = DIG_DASH; hundreds_nxt = DIG_DASH;
        tens_nxt      = DIG_DASH; ones_nxt     = DIG_DASH;
      end
      ST_COUNT: begin
        thousands_nxt = dig(mm_nxt[7:4]); hundreds_nxt = dig(mm_nxt[3:0]);
        tens_nxt      = dig(ss_nxt[7:4]); ones_nxt     = dig(ss_nxt[3:0]);
      end
      ST_ARRIVE: begin
        if ((arr_nxt >= 5'd5 && arr_nxt < 5'd10) || arr_nxt >= 5'd15) begin
          thousands_nxt = DIG_BLANK; hundreds_nxt = DIG_BLANK;
          tens_nxt      = DIG_BLANK; ones_nxt     = DIG_BLANK;
        end else begin
          thousands_nxt = 5'd0; hundreds_nxt = 5'd0;
          tens_nxt      = 5'd0; ones_nxt     = 5'd0;
        end
      end
      ST_DWELL: begin
        thousands_nxt = DIG_DASH;         hundreds_nxt = DIG_DASH;
        tens_nxt      = dig(dw_nxt[7:4]); ones_nxt     = dig(dw_nxt[3:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      thousands <= DIG_DASH;
      hundreds  <= DIG_DASH;
      tens      <= DIG_DASH;
      ones      <= DIG_DASH;
      door_open <= 1'b0;
      arriving  <= 1'b0;
    end else begin
      thousands <= thousands_nxt;
      hundreds  <= hundreds_nxt;
      tens      <= tens_nxt;
      ones      <= ones_nxt;
      door_open <= (state_nxt == ST_DWELL);
      arriving  <= (state_nxt == ST_ARRIVE);
    end
  end

endmodule

// File: tb/tb_metro_sched_ctrl.sv
// tb/tb_metro_sched_ctrl.sv - directed self-checking bench for metro_sched_ctrl
module tb_metro_sched_ctrl;

  logic clk = 1'b0;
  logic reset, tick_10hz, start, hold;
  logic [4:0] ones, tens, hundreds, thousands;
  logic [4:0] ones_b, tens_b, hundreds_b, thousands_b;
  logic door_open, arriving, door_open_b, arriving_b;
  logic [7:0] train_cnt, train_cnt_b;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  metro_sched_ctrl #(.INTERVAL_MM(0), .INTERVAL_SS(3), .DWELL_S(2)) u_dut (
    .clk(clk), .reset(reset), .tick_10hz(tick_10hz), .start(start), .hold(hold),
    .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
    .door_open(door_open), .arriving(arriving), .train_cnt(train_cnt)
  );

  metro_sched_ctrl #(.INTERVAL_MM(1), .INTERVAL_SS(0), .DWELL_S(2)) u_dut_b (
    .clk(clk), .reset(reset), .tick_10hz(tick_10hz), .start(start), .hold(hold),
    .ones(ones_b), .tens(tens_b), .hundreds(hundreds_b), .thousands(thousands_b),
    .door_open(door_open_b), .arriving(arriving_b), .train_cnt(train_cnt_b)
  );

  function automatic logic [31:0] d4(input int a, input int b, input int c, input int d);
    return {12'd0, 5'(a), 5'(b), 5'(c), 5'(d)};
  endfunction

  function automatic logic [31:0] disp();
    return {12'd0, thousands, hundreds, tens, ones};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change at negedge; each tick is a one-clk pulse followed by one quiet clk
  task automatic do_tick(input int n);
    repeat (n) begin
      tick_10hz = 1'b1;
      @(negedge clk);
      tick_10hz = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; hold = 1'b1; tick_10hz = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("reset_digits", disp(), d4(17, 17, 17, 17));
    check_val("reset_train", {24'd0, train_cnt}, 32'd0);
    check_val("reset_flags", {30'd0, door_open, arriving}, 32'd0);
    check_val("reset_b_arriving", {31'd0, arriving_b}, 32'd0);
    reset = 1'b0; start = 1'b0; hold = 1'b0; tick_10hz = 1'b0;
    @(negedge clk);

    hold = 1'b1;
    do_tick(15);
    hold = 1'b0;
    check_val("idle_ignores_hold_tick", disp(), d4(17, 17, 17, 17));

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("start_load", disp(), d4(0, 0, 0, 3));
    check_val("start_load_b", {12'd0, thousands_b, hundreds_b, tens_b, ones_b}, d4(0, 1, 0, 0));
    do_tick(10);
    check_val("first_second", disp(), d4(0, 0, 0, 2));
    check_val("borrow_b", {12'd0, thousands_b, hundreds_b, tens_b, ones_b}, d4(0, 0, 5, 9));

    do_tick(4);
    hold = 1'b1;
    do_tick(30);
    check_val("hold_frozen", disp(), d4(0, 0, 0, 2));
    hold = 1'b0;
    @(negedge clk);
    do_tick(5);
    check_val("resume_5_ticks", disp(), d4(0, 0, 0, 2));
    do_tick(1);
    check_val("resume_6_ticks", disp(), d4(0, 0, 0, 1));

    do_tick(9);
    hold = 1'b1; tick_10hz = 1'b1;
    @(negedge clk);
    tick_10hz = 1'b0;
    @(negedge clk);
    check_val("hold_beats_event", disp(), d4(0, 0, 0, 1));
    hold = 1'b0;
    @(negedge clk);
    do_tick(1);
    check_val("event_after_hold", disp(), d4(0, 0, 0, 0));
    do_tick(9);
    check_val("zero_not_arrived", {31'd0, arriving}, 32'd0);
    do_tick(1);
    check_val("arrive_flag", {31'd0, arriving}, 32'd1);
    check_val("arrive_zeros", disp(), d4(0, 0, 0, 0));

    do_tick(5);
    check_val("arrive_blank", disp(), d4(16, 16, 16, 16));
    do_tick(5);
    check_val("arrive_zeros2", disp(), d4(0, 0, 0, 0));
    do_tick(9);
    check_val("arrive_blank_last", disp(), d4(16, 16, 16, 16));
    check_val("arrive_still", {31'd0, arriving}, 32'd1);
    do_tick(1);
    check_val("dwell_flags", {30'd0, door_open, arriving}, 32'd2);
    check_val("dwell_digits", disp(), d4(17, 17, 0, 2));
    do_tick(10);
    check_val("dwell_dec", disp(), d4(17, 17, 0, 1));
    do_tick(10);
    check_val("dwell_end_door", {31'd0, door_open}, 32'd0);
    check_val("dwell_end_digits", disp(), d4(0, 0, 0, 3));
    check_val("train_one", {24'd0, train_cnt}, 32'd1);

    start = 1'b1;
    do_tick(10);
    start = 1'b0;
    check_val("start_ignored", disp(), d4(0, 0, 0, 2));
    do_tick(70);
    check_val("train_two", {24'd0, train_cnt}, 32'd2);
    repeat (253) do_tick(80);
    check_val("train_255", {24'd0, train_cnt}, 32'd255);
    do_tick(80);
    check_val("train_wrap", {24'd0, train_cnt}, 32'd0);
    check_val("wrap_digits", disp(), d4(0, 0, 0, 3));

    do_tick(60);
    check_val("dwell_again", {31'd0, door_open}, 32'd1);
    reset = 1'b1; tick_10hz = 1'b1;
    @(negedge clk);
    reset = 1'b0; tick_10hz = 1'b0;
    check_val("reset_dwell_digits", disp(), d4(17, 17, 17, 17));
    check_val("reset_dwell_door", {31'd0, door_open}, 32'd0);
    check_val("reset_dwell_train", {24'd0, train_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
